sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Upstream command engine for spi_controller. It frames a 6-byte SD-card SPI-mode command and pushes it into the controller's transmit FIFO. It then discards the 6 echo bytes and polls with 0xFF fill bytes until an R1 response arrives (MSB = 0) or a poll limit is reached. It is driven by a CPU-side MMIO register block, which sees start/busy/done/resp/timeout.

Parameters:
POLL_MAX, 8, maximum number of 0xFF poll bytes sent after the frame before declaring a timeout (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle request; sampled only in IDLE
cmd_idx  input  6  SD command index
cmd_arg  input  32  command argument, sent MSB byte first
cmd_crc  input  7  CRC7 of the frame
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse at completion (success or timeout)
resp  output  8  last response byte captured; held until the next accepted start
timeout  output  1  set with done when POLL_MAX polls fail; cleared on accepted start
spi_wr  output  1  push spi_din into the controller transmit FIFO
spi_din  output  8  byte to transmit
spi_rd  output  1  pop one byte from the controller receive FIFO
spi_dout  input  8  popped receive byte; valid at the clock edge after the spi_rd cycle
spi_data_avail  input  1  receive FIFO non-empty
spi_buffer_full  input  1  transmit FIFO full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every output is 0; state is IDLE; all counters are 0. rst is shared with spi_controller, so both FIFOs are flushed together.
- Reset mid-operation aborts immediately: no done pulse, resp = 0, timeout = 0.
- Frame bytes, in order:
  - B0 = {2'b01, cmd_idx}
  - B1..B4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - B5 = {cmd_crc, 1'b1}
- Frame latch: cmd_idx/arg/crc are captured into internal registers on the accepted start. Later input changes have no effect.
- FSM states: IDLE, SEND, DRAIN_RD, DRAIN_CAP, POLL_TX, POLL_RD, POLL_CAP, FINISH.
- IDLE: on start=1, latch inputs, clear timeout and resp, set tx_idx=0, rx_cnt=0, poll_cnt=0, go to SEND. busy rises the next cycle.
- SEND:
  - Each cycle with spi_buffer_full=0: spi_wr=1, spi_din=B[tx_idx], tx_idx++.
  - When spi_buffer_full=1: spi_wr=0, and tx_idx holds. No byte is lost or duplicated.
  - After B5 is written, go to DRAIN_RD.
- DRAIN_RD: wait for spi_data_avail=1, then assert spi_rd for exactly one cycle and go to DRAIN_CAP.
- DRAIN_CAP: discard spi_dout; rx_cnt++. If rx_cnt reaches 6, go to POLL_TX; otherwise return to DRAIN_RD.
- POLL_TX: when spi_buffer_full=0, spi_wr=1, spi_din=0xFF, poll_cnt++, go to POLL_RD.
- POLL_RD: wait for spi_data_avail, pulse spi_rd for one cycle, go to POLL_CAP.
- POLL_CAP: resp <= spi_dout.
  - If spi_dout[7]=0, go to FINISH with timeout=0.
  - Else if poll_cnt == POLL_MAX, go to FINISH with timeout=1.
  - Else go to POLL_TX.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Handshake rules:
  - spi_rd is never asserted while spi_data_avail=0.
  - spi_rd is never asserted in two consecutive cycles.
  - spi_wr is never asserted while spi_buffer_full=1.
  - spi_wr and spi_rd are never asserted in the same cycle.
- start while busy is ignored, with no effect on latched fields.
- Simultaneous start and FINISH: start is ignored (FSM not in IDLE).
- Counters: tx_idx and rx_cnt are 3-bit, poll_cnt is 8-bit. None wraps; all saturate at their terminal compare.

Test Plan:
- CMD0, arg 0x00000000, crc 0x4A; SPI model returns 0xFF x6, then 0xFF, 0x01 -> MOSI bytes 40 00 00 00 00 95 FF FF; resp=0x01; timeout=0; exactly one done pulse; busy low after done.
- CMD8, arg 0x000001AA, crc 0x43 -> frame 48 00 00 01 AA 87; first poll returns 0x05 -> resp=0x05 after exactly 1 poll byte.
- Model always returns 0xFF, POLL_MAX=8 -> exactly 8 poll bytes sent; timeout=1; resp=0xFF; done pulses once.
- spi_buffer_full forced high for 3 cycles after B1 is written -> spi_wr low throughout; B2..B5 follow in order; MOSI stream is identical to the unstalled case.
- start pulsed again during SEND with different cmd_idx -> ignored; frame and resp match the first command only.
- rst asserted during POLL_RD -> all outputs 0 immediately; no done; a following CMD0 completes normally.

Source files
------------

// File: rtl/sd_cmd_sequencer_if.sv
// Byte-level handshake between the SD command sequencer and the SPI controller FIFOs.
interface sd_cmd_sequencer_if;
  logic       spi_wr;
  logic [7:0] spi_din;
  logic       spi_rd;
  logic [7:0] spi_dout;
  logic       spi_data_avail;
  logic       spi_buffer_full;

  modport master (
    output spi_wr, spi_din, spi_rd,
    input  spi_dout, spi_data_avail, spi_buffer_full
  );

  modport slave (
    input  spi_wr, spi_din, spi_rd,
    output spi_dout, spi_data_avail, spi_buffer_full
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Frames a 6-byte SD SPI-mode command, drains its echo, then polls with 0xFF until an R1 arrives.
//   state     | meaning
//   IDLE      | waiting for start; inputs latched on accept
//   SEND      | pushing frame bytes B0..B5 into the TX FIFO
//   DRAIN_RD  | waiting for an echo byte, popping it
//   DRAIN_CAP | discarding the popped echo byte
//   POLL_TX   | pushing one 0xFF poll byte
//   POLL_RD   | waiting for the poll reply, popping it
//   POLL_CAP  | capturing the reply into resp, deciding finish/timeout/retry
//   FINISH    | done pulse, back to IDLE
module sd_cmd_sequencer #(
  parameter int unsigned POLL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [6:0]  cmd_crc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  resp_o,
  output logic        timeout_o,
  sd_cmd_sequencer_if.master spi
);

  localparam logic [7:0] POLL_MAX_B = 8'(POLL_MAX);

  typedef enum logic [2:0] {
    IDLE, SEND, DRAIN_RD, DRAIN_CAP, POLL_TX, POLL_RD, POLL_CAP, FINISH
  } state_t;

  state_t      state_q;
  logic [2:0]  tx_idx_q;
  logic [2:0]  rx_cnt_q;
  logic [7:0]  poll_cnt_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  resp_q;
  logic        timeout_q;

  logic [7:0]  frame_byte_d;
  logic        wr_d;
  logic        rd_d;

  always_comb begin
    frame_byte_d = 8'h00;
    case (tx_idx_q)
      3'd0:    frame_byte_d = {2'b01, idx_q};
      3'd1:    frame_byte_d = arg_q[31:24];
      3'd2:    frame_byte_d = arg_q[23:16];
      3'd3:    frame_byte_d = arg_q[15:8];
      3'd4:    frame_byte_d = arg_q[7:0];
      3'd5:    frame_byte_d = {crc_q, 1'b1};
      default: frame_byte_d = 8'h00;
    endcase
  end

  // FIFO strobes are gated by the live flags so a full/empty FIFO is never touched.
  assign wr_d = ((state_q == SEND) || (state_q == POLL_TX)) && !spi.spi_buffer_full;
  assign rd_d = ((state_q == DRAIN_RD) || (state_q == POLL_RD)) && spi.spi_data_avail;

  assign spi.spi_wr  = wr_d;
  assign spi.spi_rd  = rd_d;
  assign spi.spi_din = (state_q == POLL_TX) ? 8'hFF :
                       (state_q == SEND)    ? frame_byte_d : 8'h00;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign resp_o    = resp_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_idx_q   <= '0;
      rx_cnt_q   <= '0;
      poll_cnt_q <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      crc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_q      <= cmd_idx_i;
            arg_q      <= cmd_arg_i;
            crc_q      <= cmd_crc_i;
            timeout_q  <= 1'b0;
            resp_q     <= '0;
            tx_idx_q   <= '0;
            rx_cnt_q   <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (!spi.spi_buffer_full) begin
            if (tx_idx_q == 3'd5) state_q  <= DRAIN_RD;
            else                  tx_idx_q <= tx_idx_q + 3'd1;
          end
        end
        DRAIN_RD: begin
          if (spi.spi_data_avail) state_q <= DRAIN_CAP;
        end
        DRAIN_CAP: begin
          if (rx_cnt_q != 3'd6) rx_cnt_q <= rx_cnt_q + 3'd1;
          state_q <= (rx_cnt_q >= 3'd5) ? POLL_TX : DRAIN_RD;
        end
        POLL_TX: begin
          if (!spi.spi_buffer_full) begin
            if (poll_cnt_q != 8'hFF) poll_cnt_q <= poll_cnt_q + 8'd1;
            state_q <= POLL_RD;
          end
        end
        POLL_RD: begin
          if (spi.spi_data_avail) state_q <= POLL_CAP;
        end
        POLL_CAP: begin
          resp_q <= spi.spi_dout;
          if (!spi.spi_dout[7]) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (poll_cnt_q >= POLL_MAX_B) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= FINISH;
          end else begin
            state_q <= POLL_TX;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench: a queue-based SPI controller model echoes scripted bytes; monitors compare MOSI and completions.
module tb_sd_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy, done, timeout;
  logic [7:0]  resp;

  sd_cmd_sequencer_if spi();

  sd_cmd_sequencer #(.POLL_MAX(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .cmd_idx_i (cmd_idx),
    .cmd_arg_i (cmd_arg),
    .cmd_crc_i (cmd_crc),
    .busy_o    (busy),
    .done_o    (done),
    .resp_o    (resp),
    .timeout_o (timeout),
    .spi       (spi.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int rx_n = 0;
  logic hold_rx = 1'b0;

  logic [7:0] script[$];
  logic [7:0] rxq[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_resp[$];
  logic       exp_to[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI controller model: each pushed byte yields one scripted reply (0xFF when the script is empty).
  assign spi.spi_data_avail = (rx_n != 0) && !hold_rx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rxq.delete();
      rx_n <= 0;
      spi.spi_dout <= 8'h00;
    end else begin
      if (spi.spi_wr) begin
        wr_cnt <= wr_cnt + 1;
        if (script.size() > 0) rxq.push_back(script.pop_front());
        else                   rxq.push_back(8'hFF);
      end
      if (spi.spi_rd && rxq.size() > 0) spi.spi_dout <= rxq.pop_front();
      rx_n <= rxq.size();
    end
  end

  // Monitor: compares each write, checks handshake rules, scores each done pulse.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (spi.spi_wr) begin
        chk("wr_while_full", spi.spi_buffer_full, 0);
        if (exp_mosi.size() == 0) begin
          checks++; errors++;
          $display("FAIL mosi_unexpected: got 0x%0h expected no write at %0t", spi.spi_din, $time);
        end else begin
          chk("mosi_byte", spi.spi_din, exp_mosi.pop_front());
        end
      end
      if (spi.spi_rd) begin
        chk("rd_avail", spi.spi_data_avail, 1);
        chk("rd_and_wr", spi.spi_wr, 0);
        chk("rd_consecutive", prev_rd, 0);
      end
      prev_rd = spi.spi_rd;
      if (done) begin
        done_cnt = done_cnt + 1;
        chk("busy_at_done", busy, 0);
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 expected none at %0t", $time);
        end else begin
          chk("resp", resp, exp_resp.pop_front());
          chk("timeout", timeout, exp_to.pop_front());
        end
      end
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) exp_mosi.push_back(b[i]);
  endtask

  task automatic expect_done(input logic [7:0] r, input logic t);
    exp_resp.push_back(r);
    exp_to.push_back(t);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    @(posedge clk); #1;
    cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_idx = 6'h3F; cmd_arg = 32'hDEADBEEF; cmd_crc = 7'h00;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) break;
    end
    chk("done_seen", (done_cnt > d0), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("mosi_remaining", exp_mosi.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic wait_writes(input int base, input int n);
    for (int i = 0; i < 200; i++) begin
      if (wr_cnt - base >= n) break;
      @(posedge clk); #1;
    end
    chk("write_count_reached", (wr_cnt - base >= n), 1);
  endtask

  int d0, base;

  initial begin
    rst = 1'b1; start = 1'b0; cmd_idx = '0; cmd_arg = '0; cmd_crc = '0;
    spi.spi_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_spi_wr", spi.spi_wr, 0);
    chk("rst_spi_rd", spi.spi_rd, 0);
    chk("rst_spi_din", spi.spi_din, 0);
    rst = 1'b0;

    // CMD0: one 0xFF poll then R1 = 0x01
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_bytes('{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF});
    expect_done(8'h01, 1'b0);
    d0 = done_cnt;
    issue(6'd0, 32'h0000_0000, 7'h4A);
    wait_done(d0);
    chk("resp_held", resp, 8'h01);

    // CMD8: first poll answers 0x05
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    push_bytes('{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF});
    expect_done(8'h05, 1'b0);
    d0 = done_cnt;
    issue(6'd8, 32'h0000_01AA, 7'h43);
    wait_done(d0);

    // CMD55 with card never answering: 8 polls, timeout
    script.delete();
    push_bytes('{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    expect_done(8'hFF, 1'b1);
    d0 = done_cnt;
    base = wr_cnt;
    issue(6'd55, 32'h0000_0000, 7'h32);
    wait_done(d0);
    chk("timeout_writes", wr_cnt - base, 14);

    // CMD17 with TX FIFO full for 3 cycles after B1
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    push_bytes('{8'h51, 8'h12, 8'h34, 8'h56, 8'h78, 8'h55, 8'hFF});
    expect_done(8'h00, 1'b0);
    d0 = done_cnt;
    base = wr_cnt;
    issue(6'd17, 32'h1234_5678, 7'h2A);
    wait_writes(base, 2);
    spi.spi_buffer_full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_writes", wr_cnt - base, 2);
    spi.spi_buffer_full = 1'b0;
    wait_done(d0);

    // second start during SEND is ignored
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_bytes('{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF});
    expect_done(8'h01, 1'b0);
    d0 = done_cnt;
    issue(6'd0, 32'h0000_0000, 7'h4A);
    cmd_idx = 6'd8; cmd_arg = 32'h0000_01AA; cmd_crc = 7'h43; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0);

    // reset while waiting in POLL_RD
    hold_rx = 1'b1;
    script.delete();
    push_bytes('{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF});
    d0 = done_cnt;
    base = wr_cnt;
    issue(6'd0, 32'h0000_0000, 7'h4A);
    hold_rx = 1'b0;
    wait_writes(base, 6);
    hold_rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    hold_rx = 1'b0;
    wait_writes(base, 7);
    hold_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_resp", resp, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_spi_wr", spi.spi_wr, 0);
    chk("abort_spi_rd", spi.spi_rd, 0);
    chk("abort_mosi_remaining", exp_mosi.size(), 0);
    exp_mosi.delete(); exp_resp.delete(); exp_to.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_bytes('{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF});
    expect_done(8'h01, 1'b0);
    d0 = done_cnt;
    issue(6'd0, 32'h0000_0000, 7'h4A);
    wait_done(d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
